snake_key_event: RTL and testbench



---
 rtl/snake_key_event.sv | 187 ++++++++++++++++++
 tb/tb_snake_key_event.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_key_event.sv
// snake_key_event: turns four debounced direction-key levels into discrete
// direction events for the snake game FSM.
//
// How it works:
//   - Detects press edges on the keys.
//   - Arbitrates simultaneous presses; the lowest index wins.
//   - Tracks the owning key through an IDLE/HOLD(/REPEAT) FSM.
//   - Delivers events through a one-entry valid/ready buffer.
//
// Build option: define SNAKE_KEY_EVENT_REPEAT_EN to enable hold-to-repeat
// events. Without it the FSM only tracks press/takeover/release and
// evt_repeat is tied to 0.
//
// Handshake: an event is transferred on a rising edge where
// evt_valid && evt_ready.
//   - While evt_valid=1 and evt_ready=0, evt_dir/evt_repeat stay stable,
//     except when a fresh press event overwrites the pending entry.
//   - A repeat event that finds the buffer full and not draining is dropped.
module snake_key_event #(
   parameter int HOLD_CYCLES   = 1_000,
   parameter int REPEAT_CYCLES = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_v,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic [1:0] evt_dir,
   output logic       evt_repeat,
   output logic       held
);

   // Both intervals must be at least two cycles long.
   if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("snake_key_event: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
   end

`ifdef SNAKE_KEY_EVENT_REPEAT_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic          emit_rep;
`else
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;
`endif

   state_t     state;
   state_t     state_n;
   logic [3:0] key_prev;
   logic [3:0] press;
   logic [3:0] takeover;
   logic [1:0] owner;
   logic [1:0] owner_n;
   logic       emit;
   logic [1:0] emit_dir;
   logic       consume;
   logic       load;

   // Lowest set index wins: up > down > left > right.
   function automatic logic [1:0] pick(input logic [3:0] v);
      logic [1:0] r;
      casez (v)
         4'b???1: r = 2'd0;
         4'b??10: r = 2'd1;
         4'b?100: r = 2'd2;
         default: r = 2'd3;
      endcase
      return r;
   endfunction

   assign press    = key_v & ~key_prev;
   // The owner cannot produce an edge while it is held; masking it keeps the
   // takeover test to "some other key".
   assign takeover = press & ~(4'b0001 << owner);
   assign consume  = evt_valid & evt_ready;

`ifdef SNAKE_KEY_EVENT_REPEAT_EN
   // Press events always land; repeat events need a free or draining slot.
   assign load = emit & (~evt_valid | consume | ~emit_rep);
`else
   assign load = emit;
   assign evt_repeat = 1'b0;
`endif

   // Next-state, owner, counter and event-emit decisions.
   always_comb begin
      state_n  = state;
      owner_n  = owner;
      emit     = 1'b0;
      emit_dir = owner;
`ifdef SNAKE_KEY_EVENT_REPEAT_EN
      emit_rep = 1'b0;
      cnt_n    = cnt;
`endif
      case (state)
         IDLE: begin
            if (|press) begin
               emit     = 1'b1;
               emit_dir = pick(press);
               owner_n  = pick(press);
               state_n  = HOLD;
`ifdef SNAKE_KEY_EVENT_REPEAT_EN
               cnt_n    = '0;
`endif
            end
         end
         default: begin
            // HOLD and REPEAT share takeover and release handling.
            if (|takeover) begin
               emit     = 1'b1;
               emit_dir = pick(takeover);
               owner_n  = pick(takeover);
               state_n  = HOLD;
`ifdef SNAKE_KEY_EVENT_REPEAT_EN
               cnt_n    = '0;
`endif
            end else if (!key_v[owner]) begin
               state_n = IDLE;
            end
`ifdef SNAKE_KEY_EVENT_REPEAT_EN
            else if (cnt == ((state == REPEAT) ? REP_LAST : HOLD_LAST)) begin
               emit     = 1'b1;
               emit_rep = 1'b1;
               cnt_n    = '0;
               state_n  = REPEAT;
            end else begin
               cnt_n = cnt + 1'b1;
            end
`endif
         end
      endcase
   end

   // Key history, FSM state, owner, counter and the registered held flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_prev <= 4'b1111;
         state    <= IDLE;
         owner    <= 2'd0;
         held     <= 1'b0;
`ifdef SNAKE_KEY_EVENT_REPEAT_EN
         cnt      <= '0;
`endif
      end else begin
         key_prev <= key_v;
         state    <= state_n;
         owner    <= owner_n;
         held     <= (state_n != IDLE);
`ifdef SNAKE_KEY_EVENT_REPEAT_EN
         cnt      <= cnt_n;
`endif
      end
   end

   // One-entry event buffer: load, overwrite, or drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         evt_valid  <= 1'b0;
         evt_dir    <= 2'd0;
`ifdef SNAKE_KEY_EVENT_REPEAT_EN
         evt_repeat <= 1'b0;
`endif
      end else if (load) begin
         evt_valid  <= 1'b1;
         evt_dir    <= emit_dir;
`ifdef SNAKE_KEY_EVENT_REPEAT_EN
         evt_repeat <= emit_rep;
`endif
      end else if (consume) begin
         evt_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_snake_key_event.sv
// tb_snake_key_event: directed scenarios plus randomized key/ready traffic
// for snake_key_event (HOLD_CYCLES=8, REPEAT_CYCLES=4), checked every cycle
// against an event model built on elapsed-cycle arithmetic.
// Follows SNAKE_KEY_EVENT_REPEAT_EN the same way the design does.
module tb_snake_key_event;

   localparam int H = 8;
   localparam int R = 4;
`ifdef SNAKE_KEY_EVENT_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key_v = 4'b0000;
   logic       evt_ready = 1'b0;
   logic       evt_valid;
   logic [1:0] evt_dir;
   logic       evt_repeat;
   logic       held;

   always #5 clk = ~clk;

   snake_key_event #(
      .HOLD_CYCLES(H),
      .REPEAT_CYCLES(R)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key_v(key_v),
      .evt_ready(evt_ready),
      .evt_valid(evt_valid),
      .evt_dir(evt_dir),
      .evt_repeat(evt_repeat),
      .held(held)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   // An owner key emits a press at time t0, then repeats at t0+H, t0+H+R, ...
   // for as long as it stays held and no other key is freshly pressed.
   logic [3:0] m_prev = 4'b1111;
   logic       m_active = 1'b0;
   int         m_owner = 0;
   int         m_t0 = 0;
   int         m_cyc = 0;
   logic       m_valid = 1'b0;
   logic [1:0] m_dir = 2'd0;
   logic       m_rep = 1'b0;

   logic [10:0] exp_q[$];
   logic [10:0] got_q[$];

   function automatic logic [1:0] first_set(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
      return 2'd0;
   endfunction

   task automatic model_step();
      logic [3:0] edges;
      logic [3:0] others;
      logic       e;
      logic       er;
      logic [1:0] ed;
      logic       cons;
      int         d;
      m_cyc++;
      if (rst) begin
         m_prev = 4'b1111; m_active = 1'b0; m_owner = 0;
         m_valid = 1'b0; m_dir = 2'd0; m_rep = 1'b0;
         return;
      end
      edges = key_v & ~m_prev;
      m_prev = key_v;
      e = 1'b0; er = 1'b0; ed = 2'd0;
      others = edges;
      if (m_active) others[m_owner] = 1'b0;
      if (others != 4'b0) begin
         e = 1'b1; ed = first_set(others);
         m_active = 1'b1; m_owner = int'(ed); m_t0 = m_cyc;
      end else if (m_active && !key_v[m_owner]) begin
         m_active = 1'b0;
      end else if (m_active && REP_EN) begin
         d = m_cyc - m_t0;
         if (d >= H && ((d - H) % R) == 0) begin
            e = 1'b1; er = 1'b1; ed = 2'(m_owner);
         end
      end
      cons = m_valid && evt_ready;
      if (e && (!m_valid || cons || !er)) begin
         m_valid = 1'b1; m_dir = ed; m_rep = er;
      end else if (cons) begin
         m_valid = 1'b0;
      end
   endtask

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; key_v = 4'b0001; evt_ready = 1'b1;
      repeat (3) tick();
      if ({evt_valid, evt_dir, evt_repeat, held} !== 5'b0) begin
         errors++;
         $display("FAIL reset_values got=%b exp=00000", {evt_valid, evt_dir, evt_repeat, held});
      end
      checks++;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 6) key_v = 4'b0000;
         if (i == 8) key_v = 4'b0001;
         if (i == 9) key_v = 4'b0000;
         tick();
         if ({evt_valid, evt_dir, evt_repeat, held} !== {m_valid, m_dir, m_rep, m_active}) begin
            errors++;
            $display("FAIL reset cyc=%0d vdrh got=%b exp=%b", m_cyc, {evt_valid, evt_dir, evt_repeat, held}, {m_valid, m_dir, m_rep, m_active});
         end
         checks++;
         if (i == 5) begin
            if (evt_valid !== 1'b0) begin
               errors++;
               $display("FAIL held_through_reset evt_valid got=%b exp=0", evt_valid);
            end
            checks++;
         end
         if (i == 8) begin
            if ({evt_valid, evt_dir, evt_repeat} !== 4'b1000) begin
               errors++;
               $display("FAIL repress_event got=%b exp=1000", {evt_valid, evt_dir, evt_repeat});
            end
            checks++;
         end
      end
   endtask

   task automatic test_multi_press();
      int n = 0;
      evt_ready = 1'b1; key_v = 4'b0110;
      for (int i = 0; i < 7; i++) begin
         if (i == 4) key_v = 4'b0000;
         tick();
         if (evt_valid) n++;
         if ({evt_valid, evt_dir, evt_repeat, held} !== {m_valid, m_dir, m_rep, m_active}) begin
            errors++;
            $display("FAIL multi_press cyc=%0d vdrh got=%b exp=%b", m_cyc, {evt_valid, evt_dir, evt_repeat, held}, {m_valid, m_dir, m_rep, m_active});
         end
         checks++;
         if (i == 0) begin
            if ({evt_valid, evt_dir} !== 3'b101) begin
               errors++;
               $display("FAIL multi_press_winner got=%b exp=101", {evt_valid, evt_dir});
            end
            checks++;
         end
      end
      if (n != 1) begin
         errors++;
         $display("FAIL multi_press_count got=%0d exp=1", n);
      end
      checks++;
   endtask

   task automatic test_hold_repeat();
      exp_q = {};
      got_q = {};
      exp_q.push_back({8'd0, 2'd3, 1'b0});
      if (REP_EN) begin
         exp_q.push_back({8'd8, 2'd3, 1'b1});
         exp_q.push_back({8'd12, 2'd3, 1'b1});
         exp_q.push_back({8'd16, 2'd3, 1'b1});
      end
      evt_ready = 1'b1; key_v = 4'b1000;
      for (int i = 0; i < 30; i++) begin
         if (i == 20) key_v = 4'b0000;
         tick();
         if (evt_valid) got_q.push_back({8'(i), evt_dir, evt_repeat});
         if ({evt_valid, evt_dir, evt_repeat, held} !== {m_valid, m_dir, m_rep, m_active}) begin
            errors++;
            $display("FAIL hold_repeat cyc=%0d vdrh got=%b exp=%b", m_cyc, {evt_valid, evt_dir, evt_repeat, held}, {m_valid, m_dir, m_rep, m_active});
         end
         checks++;
         if (i == 20) begin
            if (held !== 1'b0) begin
               errors++;
               $display("FAIL release_held got=%b exp=0", held);
            end
            checks++;
         end
      end
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL hold_repeat_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL hold_repeat_event%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
            checks++;
         end
      end
      checks++;
   endtask

   task automatic test_takeover();
      exp_q = {};
      got_q = {};
      exp_q.push_back({8'd0, 2'd0, 1'b0});
      exp_q.push_back({8'd3, 2'd2, 1'b0});
      if (REP_EN) begin
         exp_q.push_back({8'd11, 2'd2, 1'b1});
         exp_q.push_back({8'd15, 2'd2, 1'b1});
      end
      evt_ready = 1'b1; key_v = 4'b0001;
      for (int i = 0; i < 22; i++) begin
         if (i == 3) key_v = 4'b0101;
         if (i == 6) key_v = 4'b0100;
         if (i == 18) key_v = 4'b0000;
         tick();
         if (evt_valid) got_q.push_back({8'(i), evt_dir, evt_repeat});
         if ({evt_valid, evt_dir, evt_repeat, held} !== {m_valid, m_dir, m_rep, m_active}) begin
            errors++;
            $display("FAIL takeover cyc=%0d vdrh got=%b exp=%b", m_cyc, {evt_valid, evt_dir, evt_repeat, held}, {m_valid, m_dir, m_rep, m_active});
         end
         checks++;
      end
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL takeover_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL takeover_event%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
            checks++;
         end
      end
      checks++;
   endtask

   task automatic test_backpressure();
      int drained = 0;
      evt_ready = 1'b0; key_v = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         if (i == 13) key_v = 4'b0011;
         if (i == 14) evt_ready = 1'b1;
         if (i == 17) key_v = 4'b0000;
         if (evt_valid && evt_ready) drained++;
         tick();
         if ({evt_valid, evt_dir, evt_repeat, held} !== {m_valid, m_dir, m_rep, m_active}) begin
            errors++;
            $display("FAIL backpressure cyc=%0d vdrh got=%b exp=%b", m_cyc, {evt_valid, evt_dir, evt_repeat, held}, {m_valid, m_dir, m_rep, m_active});
         end
         checks++;
         if (i == 12) begin
            if ({evt_valid, evt_dir, evt_repeat} !== 4'b1000) begin
               errors++;
               $display("FAIL stalled_buffer got=%b exp=1000", {evt_valid, evt_dir, evt_repeat});
            end
            checks++;
         end
         if (i == 13) begin
            if ({evt_valid, evt_dir, evt_repeat} !== 4'b1010) begin
               errors++;
               $display("FAIL overwrite got=%b exp=1010", {evt_valid, evt_dir, evt_repeat});
            end
            checks++;
         end
      end
      if (drained != 1) begin
         errors++;
         $display("FAIL drain_count got=%0d exp=1", drained);
      end
      checks++;
   endtask

   task automatic test_random();
      int b;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            b = $urandom_range(0, 3);
            key_v[b] = ~key_v[b];
         end
         evt_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 99) == 0);
         if (i >= 590) begin
            rst = 1'b0; key_v = 4'b0000; evt_ready = 1'b1;
         end
         tick();
         if ({evt_valid, evt_dir, evt_repeat, held} !== {m_valid, m_dir, m_rep, m_active}) begin
            errors++;
            $display("FAIL random cyc=%0d vdrh got=%b exp=%b", m_cyc, {evt_valid, evt_dir, evt_repeat, held}, {m_valid, m_dir, m_rep, m_active});
         end
         checks++;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_multi_press();
      test_hold_repeat();
      test_takeover();
      test_backpressure();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
